// File: rtl/alu_issue_unit.sv
// Fetch/issue stage for the two-phase ALU pipeline: steps a PC through a small
// program RAM and issues one decoded instruction per clock, inserting bubbles on RAW hazards.
module alu_issue_unit #(
  parameter int PROG_DEPTH = 64,
  parameter int PC_W       = 6,
  parameter int HAZ_WIN    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_waddr,
  input  logic [23:0]     prog_wdata,
  input  logic            stall_in,
  output logic [3:0]      func,
  output logic [3:0]      rs1,
  output logic [3:0]      rs2,
  output logic [3:0]      rd,
  output logic [7:0]      addr,
  output logic            issue_valid,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic [15:0]     bubble_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, BUBBLE, HALT} state_t;

  state_t              state;
  logic [23:0]         mem [PROG_DEPTH];
  logic [23:0]         instr_p0;
  logic [3:0]          hist_rd [HAZ_WIN];
  logic [HAZ_WIN-1:0]  hist_vld;
  logic                active;
  logic                advance;
  logic                is_halt;
  logic                hazard;
  logic                issue_go;
  logic                bubble_go;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign active    = (state == RUN) || (state == BUBBLE);
  assign busy      = active;
  assign halted    = (state == HALT);
  assign advance   = active && !stall_in;
  assign instr_p0  = mem[pc];
  assign is_halt   = (instr_p0[23:20] == 4'hF);
  assign issue_go  = advance && !is_halt && !hazard;
  assign bubble_go = advance && !is_halt && hazard;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_WIN; i++) begin
      if (hist_vld[i] && ((hist_rd[i] == instr_p0[19:16]) || (hist_rd[i] == instr_p0[15:12])))
        hazard = 1'b1;
    end
  end

  // Program loading is only allowed while the fetch path is parked.
  always_ff @(posedge clk) begin
    if (prog_we && !active)
      mem[prog_waddr] <= prog_wdata;
  end

  always_ff @(posedge clk) begin
    if (issue_go || bubble_go) begin
      hist_rd[0] <= issue_go ? instr_p0[11:8] : 4'h0;
      for (int i = 1; i < HAZ_WIN; i++)
        hist_rd[i] <= hist_rd[i-1];
    end
  end

  // Issue stage: registers selected at this edge drive the outputs directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= '0;
      issue_valid <= 1'b0;
      func        <= 4'h0;
      rs1         <= 4'h0;
      rs2         <= 4'h0;
      rd          <= 4'h0;
      addr        <= 8'h00;
      bubble_cnt  <= 16'h0000;
      hist_vld    <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          issue_valid <= 1'b0;
          if (start) begin
            pc         <= '0;
            bubble_cnt <= 16'h0000;
            hist_vld   <= '0;
            state      <= RUN;
          end
        end
        default: begin
          if (!stall_in) begin
            if (is_halt) begin
              issue_valid <= 1'b0;
              state       <= HALT;
            end else if (hazard) begin
              issue_valid <= 1'b0;
              bubble_cnt  <= sat_inc(bubble_cnt);
              state       <= BUBBLE;
            end else begin
              func        <= instr_p0[23:20];
              rs1         <= instr_p0[19:16];
              rs2         <= instr_p0[15:12];
              rd          <= instr_p0[11:8];
              addr        <= instr_p0[7:0];
              issue_valid <= 1'b1;
              pc          <= pc + 1'b1;
              // The last word ends the program; the wrapped pc is never fetched.
              state       <= (pc == PC_W'(PROG_DEPTH - 1)) ? HALT : RUN;
            end
          end
        end
      endcase
      if (issue_go || bubble_go) begin
        hist_vld[0] <= issue_go;
        for (int i = 1; i < HAZ_WIN; i++)
          hist_vld[i] <= hist_vld[i-1];
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit: directed programs, expected issues queued
// up front, a negedge monitor pops and compares every fresh issue.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        prog_we = 1'b0;
  logic [5:0]  prog_waddr = '0;
  logic [23:0] prog_wdata = '0;
  logic        stall_in = 1'b0;
  logic [3:0]  func, rs1, rs2, rd;
  logic [7:0]  addr;
  logic        issue_valid;
  logic [5:0]  pc;
  logic        busy, halted;
  logic [15:0] bubble_cnt;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          issue_cnt = 0;
  logic        stall_q = 1'b0;
  logic [23:0] sb [$];
  int          issue_cyc [$];

  alu_issue_unit #(.PROG_DEPTH(64), .PC_W(6), .HAZ_WIN(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we),
    .prog_waddr(prog_waddr), .prog_wdata(prog_wdata), .stall_in(stall_in),
    .func(func), .rs1(rs1), .rs2(rs2), .rd(rd), .addr(addr),
    .issue_valid(issue_valid), .pc(pc), .busy(busy), .halted(halted),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    stall_q <= stall_in;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A fresh issue is one that appears after an edge where stall_in was low.
  always @(negedge clk) begin
    if (rst_n && issue_valid && !stall_q) begin
      issue_cnt++;
      issue_cyc.push_back(cyc);
      if (sb.size() == 0)
        chk("unexpected_issue", {8'h0, func, rs1, rs2, rd, addr}, 32'hFFFFFFFF);
      else
        chk("issue_fields", {8'h0, func, rs1, rs2, rd, addr}, {8'h0, sb.pop_front()});
    end
  end

  function automatic logic [23:0] ins(input logic [3:0] f, input logic [3:0] a,
                                      input logic [3:0] b, input logic [3:0] d,
                                      input logic [7:0] ad);
    return {f, a, b, d, ad};
  endfunction

  task automatic wr(input logic [5:0] a, input logic [23:0] w);
    @(negedge clk);
    prog_we = 1'b1; prog_waddr = a; prog_wdata = w;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic do_start();
    issue_cyc.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_halt(input int max);
    int n = 0;
    while (!halted && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("halt_reached", {31'h0, halted}, 32'h1);
  endtask

  task automatic load_two(input logic [23:0] w0, input logic [23:0] w1);
    wr(6'd0, w0);
    wr(6'd1, w1);
    wr(6'd2, ins(4'hF, 4'h0, 4'h0, 4'h0, 8'h00));
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    chk("reset_valid", {31'h0, issue_valid}, 32'h0);
    chk("reset_pc", {26'h0, pc}, 32'h0);
    chk("reset_bubbles", {16'h0, bubble_cnt}, 32'h0);
    chk("reset_busy_halted", {30'h0, busy, halted}, 32'h0);
    rst_n = 1'b1;

    // Two independent instructions, then HALT opcode
    load_two(ins(4'h0, 4'h1, 4'h2, 4'h3, 8'h10), ins(4'h5, 4'h4, 4'h5, 4'h6, 8'h11));
    sb.push_back(ins(4'h0, 4'h1, 4'h2, 4'h3, 8'h10));
    sb.push_back(ins(4'h5, 4'h4, 4'h5, 4'h6, 8'h11));
    do_start();
    wait_halt(20);
    chk("t2_issue_count", issue_cyc.size(), 2);
    if (issue_cyc.size() == 2) chk("t2_consecutive", issue_cyc[1] - issue_cyc[0], 1);
    chk("t2_pc", {26'h0, pc}, 32'd2);
    chk("t2_bubbles", {16'h0, bubble_cnt}, 32'd0);
    chk("t2_valid_in_halt", {31'h0, issue_valid}, 32'h0);

    // RAW on rs1: two bubbles before the dependent issue
    load_two(ins(4'h0, 4'h1, 4'h2, 4'h3, 8'h20), ins(4'h1, 4'h3, 4'h4, 4'h5, 8'h21));
    sb.push_back(ins(4'h0, 4'h1, 4'h2, 4'h3, 8'h20));
    sb.push_back(ins(4'h1, 4'h3, 4'h4, 4'h5, 8'h21));
    do_start();
    wait_halt(20);
    chk("t3_issue_count", issue_cyc.size(), 2);
    if (issue_cyc.size() == 2) chk("t3_gap", issue_cyc[1] - issue_cyc[0], 3);
    chk("t3_bubbles", {16'h0, bubble_cnt}, 32'd2);

    // Backpressure for three edges after the first issue
    load_two(ins(4'h0, 4'h1, 4'h2, 4'h3, 8'h30), ins(4'h5, 4'h4, 4'h5, 4'h6, 8'h31));
    sb.push_back(ins(4'h0, 4'h1, 4'h2, 4'h3, 8'h30));
    sb.push_back(ins(4'h5, 4'h4, 4'h5, 4'h6, 8'h31));
    do_start();
    @(negedge clk);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_stall_pc", {26'h0, pc}, 32'd1);
      chk("t4_stall_out", {23'h0, issue_valid, rd, addr[3:0]}, {23'h0, 1'b1, 4'h3, 4'h0});
    end
    stall_in = 1'b0;
    wait_halt(20);
    chk("t4_issue_count", issue_cyc.size(), 2);
    if (issue_cyc.size() == 2) chk("t4_gap", issue_cyc[1] - issue_cyc[0], 4);

    // Program write while running must be dropped
    load_two(ins(4'h0, 4'h1, 4'h2, 4'h3, 8'h40), ins(4'h2, 4'h4, 4'h5, 4'h6, 8'h41));
    sb.push_back(ins(4'h0, 4'h1, 4'h2, 4'h3, 8'h40));
    sb.push_back(ins(4'h2, 4'h4, 4'h5, 4'h6, 8'h41));
    do_start();
    prog_we = 1'b1; prog_waddr = 6'd1; prog_wdata = ins(4'h7, 4'h8, 4'h9, 4'hA, 8'hEE);
    @(negedge clk);
    prog_we = 1'b0;
    wait_halt(20);
    chk("t6_issue_count", issue_cyc.size(), 2);

    // Full 64-word program, no hazards, no wrap-around execution
    for (int i = 0; i < 64; i++) wr(6'(i), ins(4'h0, 4'h0, 4'h0, 4'h1, 8'(i)));
    for (int i = 0; i < 64; i++) sb.push_back(ins(4'h0, 4'h0, 4'h0, 4'h1, 8'(i)));
    do_start();
    wait_halt(200);
    repeat (4) @(negedge clk);
    chk("t5_issue_count", issue_cyc.size(), 64);
    chk("t5_pc_wrapped", {26'h0, pc}, 32'd0);
    chk("t5_still_halted", {30'h0, busy, halted}, 32'h1);

    // Asynchronous reset in the middle of a run
    for (int i = 0; i < 64; i++) sb.push_back(ins(4'h0, 4'h0, 4'h0, 4'h1, 8'(i)));
    do_start();
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_valid", {31'h0, issue_valid}, 32'h0);
    chk("t1_pc", {26'h0, pc}, 32'h0);
    chk("t1_idle", {30'h0, busy, halted}, 32'h0);
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_stays_idle", {26'h0, pc}, 32'h0);
    chk("t1_sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
